// File: rtl/jtl_pulse_arbiter.sv
// jtl_pulse_arbiter: shares one JTL delay line among NREQ requesters.
//   Queues per-requester pulse requests, launches them round-robin onto the line as
//   jtl_in toggles no closer than HOLDOFF cycles apart, and routes each returning
//   jtl_out toggle back to its launcher through an in-flight owner FIFO.
// Ports: clk/rst (async active-high), req[NREQ] request pulses, pend_full[NREQ]
//   saturated pending counters, jtl_in/jtl_out toggle-encoded line, done[NREQ]
//   return strobes, inflight owner-FIFO occupancy, err[2:0] sticky
//   {timeout, spurious return, dropped request}.
// Optional: define JTL_ARB_TIMEOUT_EN to enable the return watchdog (err[2]).
module jtl_pulse_arbiter #(
  parameter int NREQ    = 4,
  parameter int PEND_W  = 2,
  parameter int HOLDOFF = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          pend_full,
  output logic                     jtl_in,
  input  logic                     jtl_out,
  output logic [NREQ-1:0]          done,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [2:0]               err
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [IW:0]       NREQ_L   = (IW+1)'(NREQ);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NREQ - 1);
  localparam logic [CW-1:0]     DEPTH_L  = CW'(DEPTH);
  localparam logic [HW-1:0]     HOLD_LD  = HW'(HOLDOFF - 1);

  logic [PEND_W-1:0] pend [NREQ];
  logic [IW-1:0]     rr;
  logic [HW-1:0]     hold;
  logic [IW-1:0]     fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              jtl_prev;

  logic              grant_vld;
  logic [IW-1:0]     grant_idx;
  logic [IW:0]       scan;
  logic              launch;
  logic              ret;
  logic              nonempty;
  logic              pop;
  logic              pop_done;
  logic              tmo;
  logic [NREQ-1:0]   drop;
  logic [NREQ-1:0]   done_nxt;

  // Round-robin search from rr upward with wrap; first non-empty counter wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr} + (IW+1)'(k);
      if (scan >= NREQ_L) scan = scan - NREQ_L;
      if (!grant_vld && (pend[scan[IW-1:0]] != '0)) begin
        grant_vld = 1'b1;
        grant_idx = scan[IW-1:0];
      end
    end
  end

  // Eligibility uses the pre-pop occupancy, so a full FIFO that pops this
  // cycle still blocks the launch.
  assign launch   = grant_vld && (hold == '0) && (count != DEPTH_L);
  assign nonempty = (count != '0);
  assign ret      = jtl_out ^ jtl_prev;
  assign pop_done = ret && nonempty;
  assign pop      = pop_done || tmo;
  assign inflight = count;

  always_comb begin
    pend_full = '0;
    drop      = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_full[i] = (pend[i] == PEND_MAX);
      drop[i]      = req[i] && (pend[i] == PEND_MAX) && !(launch && (grant_idx == IW'(i)));
    end
  end

  always_comb begin
    done_nxt = '0;
    if (pop_done) done_nxt[fifo_mem[rd_ptr]] = 1'b1;
  end

`ifdef JTL_ARB_TIMEOUT_EN
  localparam int AGW = $clog2(TIMEOUT + 1);
  localparam logic [AGW-1:0] AGE_LIM = AGW'(TIMEOUT - 1);
  logic [AGW-1:0] age;

  // Age is held at zero while empty, so a push into an empty FIFO starts the
  // head's clock from zero; a return takes priority over a simultaneous expiry.
  assign tmo = nonempty && !ret && (age == AGE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (!nonempty || pop) begin
      age <= '0;
    end else begin
      age <= age + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) pend[i] <= '0;
      rr       <= '0;
      hold     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      jtl_prev <= 1'b0;
      jtl_in   <= 1'b0;
      done     <= '0;
      err      <= '0;
    end else begin
      jtl_prev <= jtl_out;
      done     <= done_nxt;

      // Request and grant to the same requester cancel out.
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !(launch && (grant_idx == IW'(i)))) begin
          if (pend[i] != PEND_MAX) pend[i] <= pend[i] + 1'b1;
        end else if (!req[i] && launch && (grant_idx == IW'(i))) begin
          pend[i] <= pend[i] - 1'b1;
        end
      end

      if (launch) begin
        jtl_in <= ~jtl_in;
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        hold   <= HOLD_LD;
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (launch && !pop)      count <= count + 1'b1;
      else if (!launch && pop) count <= count - 1'b1;

      if (|drop)            err[0] <= 1'b1;
      if (ret && !nonempty) err[1] <= 1'b1;
      if (tmo)              err[2] <= 1'b1;
    end
  end

  // Owner storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (launch) fifo_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_jtl_pulse_arbiter.sv
// Directed bench for jtl_pulse_arbiter with default parameters
// (NREQ=4, PEND_W=2, HOLDOFF=3, DEPTH=4, TIMEOUT=64); the bench drives jtl_out
// by hand to model line returns.
module tb_jtl_pulse_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] pend_full;
  logic       jtl_in;
  logic       jtl_out = 1'b0;
  logic [3:0] done;
  logic [2:0] inflight;
  logic [2:0] err;

  int checks   = 0;
  int failures = 0;

  jtl_pulse_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .pend_full (pend_full),
    .jtl_in    (jtl_in),
    .jtl_out   (jtl_out),
    .done      (done),
    .inflight  (inflight),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    jtl_out = 1'b0;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_jtl_in", jtl_in, 0);
    check("rst_done", done, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err, 0);
    check("rst_pend_full", pend_full, 0);
    ticks(2);
    rst = 1'b0;
    tick();

    // Single request with 5-cycle loopback
    req = 4'b0100;
    tick();
    req = '0;
    check("single_no_launch_yet", jtl_in, 0);
    tick();
    check("single_launch", jtl_in, 1);
    check("single_inflight1", inflight, 1);
    ticks(5);
    check("single_no_early_done", done, 0);
    jtl_out = 1'b1;
    tick();
    check("single_done2", done, 4'b0100);
    check("single_inflight0", inflight, 0);
    tick();
    check("single_done_one_cycle", done, 0);
    check("single_err", err, 0);

    // Round robin, launches 3 cycles apart
    do_reset();
    req = 4'b1111;
    tick();
    req = '0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("rr_jtl_in_t%0d", t), jtl_in, ((t + 2) / 3) & 1);
      check($sformatf("rr_inflight_t%0d", t), inflight, (t + 2) / 3);
    end
    for (int i = 0; i < 4; i++) begin
      jtl_out = ~jtl_out;
      tick();
      check($sformatf("rr_done_%0d", i), done, 4'b0001 << i);
    end
    tick();
    check("rr_done_idle", done, 0);
    check("rr_inflight_end", inflight, 0);
    check("rr_err", err, 0);

    // FIFO full: six requests, returns withheld
    do_reset();
    req = 4'b1111;
    tick();
    req = 4'b0011;
    tick();
    req = '0;
    ticks(9);
    check("full_inflight4", inflight, 4);
    check("full_jtl_in", jtl_in, 0);
    ticks(6);
    check("full_still4", inflight, 4);
    check("full_blocked", jtl_in, 0);
    check("full_pend_full", pend_full, 0);
    jtl_out = ~jtl_out;
    tick();
    check("full_pop_done0", done, 4'b0001);
    check("full_pop_inflight3", inflight, 3);
    check("full_no_launch_on_pop", jtl_in, 0);
    tick();
    check("full_fifth_launch", jtl_in, 1);
    check("full_fifth_inflight", inflight, 4);

    // Saturation of requester 0 while the FIFO is full
    req = 4'b0001;
    tick();
    tick();
    check("sat_pend2", pend_full, 0);
    tick();
    check("sat_pend3", pend_full, 4'b0001);
    check("sat_no_err_yet", err, 0);
    tick();
    req = '0;
    check("sat_drop_err", err, 3'b001);
    check("sat_still_full", pend_full, 4'b0001);

    // Spurious return
    do_reset();
    jtl_out = 1'b1;
    tick();
    check("spur_no_done", done, 0);
    check("spur_err", err, 3'b010);
    check("spur_inflight", inflight, 0);

    // Lost pulse: watchdog or stall depending on build
    do_reset();
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    check("lost_launch", jtl_in, 1);
    check("lost_inflight1", inflight, 1);
    ticks(63);
    check("lost_inflight_63", inflight, 1);
    tick();
`ifdef JTL_ARB_TIMEOUT_EN
    check("tmo_inflight0", inflight, 0);
    check("tmo_err", err, 3'b100);
    check("tmo_no_done", done, 0);
`else
    check("stall_inflight1", inflight, 1);
    check("stall_err", err, 0);
`endif

    // Asynchronous reset mid-flight
    req = 4'b1000;
    #1;
    rst = 1'b1;
    #1;
    check("arst_jtl_in", jtl_in, 0);
    check("arst_inflight", inflight, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_pend_full", pend_full, 0);
    req = '0;
    jtl_out = 1'b0;
    ticks(2);
    rst = 1'b0;
    ticks(3);
    check("post_rst_jtl_in", jtl_in, 0);
    check("post_rst_inflight", inflight, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtl_pulse_arbiter.md
# jtl_pulse_arbiter

Clocked controller that shares one JTL delay line (e.g. `jtl_vc050`) among several requesters. It queues pulse requests per requester and issues them onto the line in round-robin order, no faster than the line's recovery holdoff allows. It matches each returning pulse to the requester that launched it, using an in-flight owner FIFO. It sits between digital test/control logic and the SFQ behavioural cells, where a pulse is represented as a level toggle.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `PEND_W`, 2, per-requester pending counter width; saturates at 2^PEND_W-1
- `HOLDOFF`, 3, minimum clk cycles between successive launches (≥1)
- `DEPTH`, 4, in-flight owner FIFO depth (power of 2)
- `TIMEOUT`, 64, return watchdog limit in cycles (used only with `JTL_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  one-cycle request pulse per requester
- `pend_full`  out  NREQ  requester's pending counter is saturated
- `jtl_in`  out  1  toggle-encoded pulse driven to the JTL input
- `jtl_out`  in  1  toggle-encoded JTL output, synchronous to `clk`
- `done`  out  NREQ  one-cycle pulse to the owner of a returned pulse
- `inflight`  out  $clog2(DEPTH)+1  occupancy of the owner FIFO
- `err`  out  3  sticky error flags: [0] request dropped, [1] spurious return, [2] timeout

## Operation
- Reset values: `jtl_in`=0, `done`=0, `inflight`=0, `err`=0, `pend_full`=0. Internal state also clears: pending counters, RR pointer=0, holdoff counter=0, FIFO, `jtl_out` history=0.
- Request intake:
  - `req[i]` high increments pend[i].
  - If pend[i] is saturated and no grant to i occurs in the same cycle, the request is dropped and `err[0]` is set.
  - Request and grant to the same i in one cycle leave pend[i] unchanged.
- Launch eligibility in a cycle: holdoff counter = 0, FIFO not full, and any pend≠0.
- Grant: pick the first i with pend[i]≠0, searching from the RR pointer upward with wrap. Then:
  - toggle `jtl_in`
  - push i to the FIFO
  - decrement pend[i]
  - set RR pointer to (i+1) mod NREQ
  - load the holdoff counter with HOLDOFF-1
- Holdoff counter decrements to 0 each cycle. With HOLDOFF=1, back-to-back launches are allowed.
- Return: `jtl_out` ≠ registered previous value is one return event.
  - FIFO non-empty: pop the head owner k and pulse `done[k]`.
  - FIFO empty: no `done`, and `err[1]` is set.
- A launch and a return in the same cycle do both the push and the pop, so `inflight` is unchanged. A full FIFO popping that cycle still blocks the launch, because eligibility is evaluated before the pop.
- Error flags are sticky until `rst`.

## Timing
- `pend_full` is combinational from the pending registers.
- A request asserted in cycle t with the line idle and no holdoff: `jtl_in` toggles at the clk edge ending cycle t+1. Launch latency is 1 cycle after the pending register updates.
- Launch spacing is exactly HOLDOFF cycles when requests are continuous.
- `jtl_out` edge sampled at edge t: `done` is high during cycle t+1 for exactly 1 cycle.
- Asynchronous reset mid-flight discards all pending and in-flight pulses. If `jtl_in` was 1, the reset itself creates an edge on the line. Benches ignore returns for 2×(line delay) after reset release.

## Configuration
- `JTL_ARB_TIMEOUT_EN` defined:
  - An age counter runs while the FIFO is non-empty and resets on each pop or push-into-empty.
  - Reaching TIMEOUT pops the head without `done`, sets `err[2]`, and restarts the counter.
- Not defined: no age counter, `err[2]` is tied to 0, and a lost pulse stalls the FIFO indefinitely.

## Test plan
- Single request: `req[2]` pulse, loop `jtl_out`=`jtl_in` delayed 5 cycles → one `jtl_in` toggle, `done[2]` 6 cycles after launch, `inflight` returns to 0, `err`=0.
- Round robin: `req`=4'b1111 for one cycle, HOLDOFF=3 → launches ordered 0,1,2,3 exactly 3 cycles apart, `done` ordered identically.
- Saturation: 4 `req[0]` pulses with no line return and HOLDOFF large → `pend_full[0]`=1 after the 3rd pending accumulates, 4th dropped, `err[0]`=1.
- FIFO full: DEPTH=4, 6 requests, returns withheld → exactly 4 launches and `inflight`=4; releasing one return → a 5th launch the following eligible cycle.
- Spurious return: toggle `jtl_out` with `inflight`=0 → no `done`, `err[1]`=1.
- Timeout (macro on, TIMEOUT=64): launch, never return → at 64 cycles `inflight` goes 1→0, `err[2]`=1, no `done`. Assert `rst` mid-flight → all outputs reach their reset values at once.
